ddr3_mem_controller: RTL and testbench

Controller end of the DDR3 command/data interface. It accepts single-burst read and write requests from the CPU side and runs power-up init (reset, wait, ZQC). Each request becomes a close-page sequence ACT -> RD/WR -> 8-beat data burst on DQ -> PRE. It drives the memory model pins CS_N/RAS_N/CAS_N/WE_N/BA/ADDR/DQ directly.

---
 rtl/ddr3_mem_controller_pkg.sv | 48 ++++
 rtl/ddr3_mem_controller_if.sv | 29 ++
 rtl/ddr3_cont_timer.sv | 37 +++
 rtl/ddr3_mem_controller.sv | 215 +++++++++++++++++++++
 tb/tb_ddr3_mem_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_mem_controller_pkg.sv
// Shared definitions for the DDR3 controller: command pin encodings,
// controller state enum, request address layout and field slice helpers.
package ddr3_mem_controller_pkg;

   // Request address layout: {row, bank, col}
   localparam int unsigned RowW  = 15;
   localparam int unsigned BankW = 3;
   localparam int unsigned ColW  = 10;
   localparam int unsigned AddrW = RowW + BankW + ColW;

   // Command encodings on {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CmdMrs = 4'b0000;
   localparam logic [3:0] CmdRef = 4'b0001;
   localparam logic [3:0] CmdPre = 4'b0010;
   localparam logic [3:0] CmdAct = 4'b0011;
   localparam logic [3:0] CmdWr  = 4'b0100;
   localparam logic [3:0] CmdRd  = 4'b0101;
   localparam logic [3:0] CmdZqc = 4'b0110;
   localparam logic [3:0] CmdNop = 4'b0111;
   localparam logic [3:0] CmdDes = 4'b1111;

   typedef enum logic [3:0] {
      StRstHold,
      StInitWait,
      StZqc,
      StIdle,
      StAct,
      StRcdWait,
      StCmd,
      StLatWait,
      StBurst,
      StPre,
      StRpWait
   } ctrl_state_e;

   function automatic logic [RowW-1:0] addr_row(input logic [AddrW-1:0] a);
      return a[AddrW-1 -: RowW];
   endfunction

   function automatic logic [BankW-1:0] addr_bank(input logic [AddrW-1:0] a);
      return a[ColW +: BankW];
   endfunction

   function automatic logic [ColW-1:0] addr_col(input logic [AddrW-1:0] a);
      return a[ColW-1:0];
   endfunction

endpackage

// File: rtl/ddr3_mem_controller_if.sv
// CPU-side request/response bundle of the DDR3 controller.
//   req_valid/req_ready : request handshake, accepted when both high at a clock edge
//   req_we/addr/wdata   : write flag, {row,bank,col} address, 8-byte write burst
//   rsp_valid/rsp_rdata : one-cycle read completion pulse and the 8-byte read burst
//   wr_done             : one-cycle write completion pulse
// master = CPU side, slave = controller.
interface ddr3_mem_controller_if;
   import ddr3_mem_controller_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [AddrW-1:0] req_addr;
   logic [63:0]      req_wdata;
   logic             rsp_valid;
   logic [63:0]      rsp_rdata;
   logic             wr_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, wr_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, wr_done
   );

endinterface

// File: rtl/ddr3_cont_timer.sv
// Loadable down-counter with a zero flag; used for every controller wait.
//   clk_i, rst_ni : clock, asynchronous active-low reset (count clears to 0)
//   load_i        : load load_val_i this cycle (takes priority over counting)
//   load_val_i    : value to load
//   zero_o        : count is zero; the counter stops at zero
module ddr3_cont_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr3_mem_controller.sv
// DDR3 controller: power-up init (reset hold, NOP wait, ZQC), then one
// close-page access per request: ACT -> RD/WR -> 8-beat burst -> PRE.
//   CK, RESET_N        : clock (posedge), asynchronous active-low reset
//   bus (slave)        : CPU request/response handshake
//   MEM_RESET_N        : memory reset
//   CS_N..WE_N, BA, ADDR : command/address pins, decoded from the current state
//   DQ                 : data bus, driven only during write burst beats
// T_RST and T_INIT are assumed >= 1; T_RCD, T_CL, T_WL, T_RP must be >= 1.
module ddr3_mem_controller
   import ddr3_mem_controller_pkg::*;
#(
   parameter int unsigned T_RST  = 4,
   parameter int unsigned T_INIT = 8,
   parameter int unsigned T_RCD  = 2,
   parameter int unsigned T_CL   = 3,
   parameter int unsigned T_WL   = 2,
   parameter int unsigned T_RP   = 2
) (
   input  logic                  CK,
   input  logic                  RESET_N,
   ddr3_mem_controller_if.slave  bus,
   output logic                  MEM_RESET_N,
   output logic                  CS_N,
   output logic                  RAS_N,
   output logic                  CAS_N,
   output logic                  WE_N,
   output logic [BankW-1:0]      BA,
   output logic [RowW-1:0]       ADDR,
   inout  wire  [7:0]            DQ
);

   // A wait lasting N cycles loads N-1 on the edge entering it. The NOP waits
   // after ACT/CMD/PRE last T-1 cycles, hence the T-2 loads.
   localparam logic [7:0] LdRst  = 8'((T_RST > 1) ? T_RST - 2 : 0);
   localparam logic [7:0] LdInit = 8'((T_INIT > 0) ? T_INIT - 1 : 0);
   localparam logic [7:0] LdRcd  = 8'((T_RCD > 1) ? T_RCD - 2 : 0);
   localparam logic [7:0] LdCl   = 8'((T_CL > 1) ? T_CL - 2 : 0);
   localparam logic [7:0] LdWl   = 8'((T_WL > 1) ? T_WL - 2 : 0);
   localparam logic [7:0] LdRp   = 8'((T_RP > 1) ? T_RP - 2 : 0);

   ctrl_state_e      state_q, state_d;
   logic             armed_q, armed_d;
   logic [2:0]       beat_q, beat_d;
   logic [AddrW-1:0] addr_q;
   logic             we_q;
   logic [63:0]      wdata_q;
   logic [63:0]      cap_q, cap_d;
   logic [63:0]      rdata_q, rdata_d;
   logic             accept;
   logic             tmr_load;
   logic [7:0]       tmr_val;
   logic             tmr_zero;
   logic [3:0]       cmd;

   ddr3_cont_timer #(
      .Width (8)
   ) u_timer (
      .clk_i      (CK),
      .rst_ni     (RESET_N),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      armed_d  = armed_q;
      beat_d   = beat_q;
      accept   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         StRstHold: begin
            // The timer is zero out of reset, so the first hold cycle arms it.
            if (!armed_q) begin
               if (T_RST <= 1) begin
                  state_d  = StInitWait;
                  tmr_load = 1'b1;
                  tmr_val  = LdInit;
               end else begin
                  armed_d  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = LdRst;
               end
            end else if (tmr_zero) begin
               state_d  = StInitWait;
               tmr_load = 1'b1;
               tmr_val  = LdInit;
            end
         end
         StInitWait: if (tmr_zero) state_d = StZqc;
         StZqc:      state_d = StIdle;
         StIdle: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = StAct;
            end
         end
         StAct: begin
            if (T_RCD > 1) begin
               state_d  = StRcdWait;
               tmr_load = 1'b1;
               tmr_val  = LdRcd;
            end else begin
               state_d = StCmd;
            end
         end
         StRcdWait: if (tmr_zero) state_d = StCmd;
         StCmd: begin
            if ((we_q ? T_WL : T_CL) > 1) begin
               state_d  = StLatWait;
               tmr_load = 1'b1;
               tmr_val  = we_q ? LdWl : LdCl;
            end else begin
               state_d = StBurst;
            end
         end
         StLatWait: if (tmr_zero) state_d = StBurst;
         StBurst: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd7) state_d = StPre;
         end
         StPre: begin
            if (T_RP > 1) begin
               state_d  = StRpWait;
               tmr_load = 1'b1;
               tmr_val  = LdRp;
            end else begin
               state_d = StIdle;
            end
         end
         StRpWait: if (tmr_zero) state_d = StIdle;
         default:  state_d = StRstHold;
      endcase
   end

   // Read capture: beat i lands in byte i; the full burst is published on the
   // edge that ends the last beat, so rsp_rdata changes only with rsp_valid.
   always_comb begin
      cap_d   = cap_q;
      rdata_d = rdata_q;
      if (state_q == StBurst && !we_q) begin
         cap_d[{beat_q, 3'b000} +: 8] = DQ;
         if (beat_q == 3'd7) rdata_d = cap_d;
      end
   end

   always_ff @(posedge CK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StRstHold;
         armed_q <= 1'b0;
         beat_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         beat_q  <= beat_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         if (accept) begin
            addr_q  <= bus.req_addr;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
         end
      end
   end

   // Pin decode
   always_comb begin
      cmd         = CmdNop;
      BA          = '0;
      ADDR        = '0;
      MEM_RESET_N = 1'b1;
      unique case (state_q)
         StRstHold: begin
            cmd         = CmdDes;
            MEM_RESET_N = 1'b0;
         end
         StZqc: begin
            cmd  = CmdZqc;
            ADDR = 15'h0400;  // A10=1: long calibration
         end
         StAct: begin
            cmd  = CmdAct;
            BA   = addr_bank(addr_q);
            ADDR = addr_row(addr_q);
         end
         StCmd: begin
            cmd  = we_q ? CmdWr : CmdRd;
            BA   = addr_bank(addr_q);
            ADDR = {5'b0, addr_col(addr_q)};
         end
         StPre: begin
            cmd = CmdPre;  // A10=0: single-bank precharge
            BA  = addr_bank(addr_q);
         end
         default: ;
      endcase
   end

   assign {CS_N, RAS_N, CAS_N, WE_N} = cmd;

   assign DQ = (state_q == StBurst && we_q) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'hzz;

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StPre) && !we_q;
   assign bus.wr_done   = (state_q == StPre) && we_q;
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ddr3_mem_controller.sv
// Bench for ddr3_mem_controller: cycle-by-cycle pin checks against the
// documented timeline, plus a response scoreboard drained by a monitor.
module tb_ddr3_mem_controller;

   localparam int TRcd = 2;
   localparam int TCl  = 3;
   localparam int TWl  = 2;
   localparam int TRp  = 2;

   localparam logic [3:0] KPre = 4'b0010;
   localparam logic [3:0] KAct = 4'b0011;
   localparam logic [3:0] KWr  = 4'b0100;
   localparam logic [3:0] KRd  = 4'b0101;
   localparam logic [3:0] KZqc = 4'b0110;
   localparam logic [3:0] KNop = 4'b0111;
   localparam logic [3:0] KDes = 4'b1111;

   typedef struct packed {
      logic        we;
      logic [63:0] data;
   } exp_t;

   logic        CK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        MEM_RESET_N, CS_N, RAS_N, CAS_N, WE_N;
   logic [2:0]  BA;
   logic [14:0] ADDR;
   wire  [7:0]  dq;
   logic        mem_oe = 1'b0;
   logic [7:0]  mem_byte = 8'h00;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errs = 0;
   logic [63:0] last_rd = '0;

   assign dq = mem_oe ? mem_byte : 8'hzz;

   ddr3_mem_controller_if bus ();

   ddr3_mem_controller #(
      .T_RST  (4),
      .T_INIT (8),
      .T_RCD  (TRcd),
      .T_CL   (TCl),
      .T_WL   (TWl),
      .T_RP   (TRp)
   ) dut (
      .CK          (CK),
      .RESET_N     (RESET_N),
      .bus         (bus),
      .MEM_RESET_N (MEM_RESET_N),
      .CS_N        (CS_N),
      .RAS_N       (RAS_N),
      .CAS_N       (CAS_N),
      .WE_N        (WE_N),
      .BA          (BA),
      .ADDR        (ADDR),
      .DQ          (dq)
   );

   always #5 CK = ~CK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // {cmd, BA, ADDR, req_ready, rsp_valid, wr_done, MEM_RESET_N}
   task automatic check_bus(input string name, input logic [3:0] c, input logic [2:0] ba,
                            input logic [14:0] a, input logic rdy, input logic rv,
                            input logic wd, input logic mrst);
      check(name,
            {38'b0, CS_N, RAS_N, CAS_N, WE_N, BA, ADDR, bus.req_ready, bus.rsp_valid,
             bus.wr_done, MEM_RESET_N},
            {38'b0, c, ba, a, rdy, rv, wd, mrst});
   endtask

   // Memory side drives a random byte whenever the controller must not drive.
   task automatic drive_probe();
      mem_oe   = 1'b1;
      mem_byte = 8'($urandom);
   endtask

   task automatic do_init(input bit with_req);
      RESET_N          = 1'b0;
      bus.req_valid    = with_req;
      bus.req_we       = 1'b0;
      bus.req_addr     = 28'($urandom);
      bus.req_wdata    = {$urandom, $urandom};
      last_rd          = '0;
      repeat (3) @(posedge CK);
      @(negedge CK);
      RESET_N = 1'b1;
      for (int n = 0; n <= 14; n++) begin
         if (n > 0) begin
            @(posedge CK);
            #1;
         end
         if (n == 13) bus.req_valid = 1'b0;
         drive_probe();
         #1;
         check_bus("init_bus", (n < 4) ? KDes : ((n == 12) ? KZqc : KNop), 3'd0,
                   (n == 12) ? 15'h0400 : 15'h0000, n >= 13, 1'b0, 1'b0, n >= 4);
         check("init_dq", {56'b0, dq}, {56'b0, mem_byte});
      end
   endtask

   // Issue one request in an IDLE cycle and check every pin up to the next
   // IDLE cycle. keep leaves req_valid high with the next request's fields.
   task automatic run_txn(input bit we, input logic [27:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input bit keep, input bit nwe,
                          input logic [27:0] naddr, input logic [63:0] nwdata,
                          input int abort_beat);
      int          cmd_c, beat0, pre_c, idle_c;
      logic [14:0] row;
      logic [2:0]  bank;
      logic [9:0]  col;
      logic [3:0]  ecmd;
      logic [2:0]  eba;
      logic [14:0] eaddr;
      logic        erv, ewd;
      logic [7:0]  edq;
      exp_t        e;
      row    = 15'(addr >> 13);
      bank   = 3'(addr >> 10);
      col    = 10'(addr);
      cmd_c  = 1 + TRcd;
      beat0  = cmd_c + (we ? TWl : TCl);
      pre_c  = beat0 + 8;
      idle_c = pre_c + TRp;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      drive_probe();
      #1;
      check("accept_ready", {63'b0, bus.req_ready}, 64'd1);
      e.we   = we;
      e.data = we ? last_rd : rdata;
      sb.push_back(e);
      if (!we) last_rd = rdata;
      for (int j = 1; j <= idle_c; j++) begin
         @(posedge CK);
         #1;
         if (j == 1) begin
            if (keep) begin
               bus.req_we    = nwe;
               bus.req_addr  = naddr;
               bus.req_wdata = nwdata;
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         ecmd  = KNop;
         eba   = 3'd0;
         eaddr = 15'd0;
         erv   = 1'b0;
         ewd   = 1'b0;
         if (j == 1) begin
            ecmd  = KAct;
            eba   = bank;
            eaddr = row;
         end else if (j == cmd_c) begin
            ecmd  = we ? KWr : KRd;
            eba   = bank;
            eaddr = {5'b0, col};
         end else if (j == pre_c) begin
            ecmd = KPre;
            eba  = bank;
            erv  = !we;
            ewd  = we;
         end
         if (j >= beat0 && j < pre_c) begin
            if (we) begin
               mem_oe = 1'b0;
               edq    = wdata[8*(j-beat0) +: 8];
            end else begin
               mem_oe   = 1'b1;
               mem_byte = rdata[8*(j-beat0) +: 8];
               edq      = mem_byte;
            end
         end else begin
            drive_probe();
            edq = mem_byte;
         end
         #1;
         check_bus("txn_bus", ecmd, eba, eaddr, j == idle_c, erv, ewd, 1'b1);
         check("txn_dq", {56'b0, dq}, {56'b0, edq});
         if (abort_beat >= 0 && j == beat0 + abort_beat) begin
            RESET_N = 1'b0;
            drive_probe();
            #1;
            check_bus("abort_bus", KDes, 3'd0, 15'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("abort_dq", {56'b0, dq}, {56'b0, mem_byte});
            void'(sb.pop_back());
            last_rd = '0;
            return;
         end
      end
   endtask

   // Response monitor: every completion pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CK);
         if (bus.rsp_valid || bus.wr_done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL sb_unexpected: got rsp_valid=%0b wr_done=%0b, expected no pulse at %0t",
                        bus.rsp_valid, bus.wr_done, $time);
            end else begin
               e = sb.pop_front();
               check("sb_kind", {62'b0, bus.rsp_valid, bus.wr_done}, e.we ? 64'd1 : 64'd2);
               check("sb_rdata", bus.rsp_rdata, e.data);
            end
         end
      end
   end

   initial begin
      logic        r_we[12];
      logic [27:0] r_addr[12];
      logic [63:0] r_wd[12];
      logic [63:0] r_rd[12];
      logic [27:0] a0, a1;
      logic [63:0] d0, d1;
      bit          keep;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Init with a request pending the whole time
      do_init(1'b1);

      // Directed read: row 5, bank 2, col 16
      run_txn(1'b0, {15'd5, 3'd2, 10'd16}, 64'd0, 64'h1716151413121110,
              1'b0, 1'b0, 28'd0, 64'd0, -1);
      // Directed write
      run_txn(1'b1, 28'($urandom), 64'h8877665544332211, 64'd0,
              1'b0, 1'b0, 28'd0, 64'd0, -1);

      // Back-to-back read then write with req_valid held high
      a0 = 28'($urandom);
      a1 = 28'($urandom);
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      run_txn(1'b0, a0, 64'd0, d0, 1'b1, 1'b1, a1, d1, -1);
      run_txn(1'b1, a1, d1, 64'd0, 1'b0, 1'b0, 28'd0, 64'd0, -1);

      // Random mix
      for (int i = 0; i < 12; i++) begin
         r_we[i]   = 1'($urandom);
         r_addr[i] = 28'($urandom);
         r_wd[i]   = {$urandom, $urandom};
         r_rd[i]   = {$urandom, $urandom};
      end
      for (int i = 0; i < 12; i++) begin
         keep = (i < 11) && ($urandom_range(0, 1) == 1);
         if (keep) begin
            run_txn(r_we[i], r_addr[i], r_wd[i], r_rd[i], 1'b1,
                    r_we[i+1], r_addr[i+1], r_wd[i+1], -1);
         end else begin
            run_txn(r_we[i], r_addr[i], r_wd[i], r_rd[i], 1'b0, 1'b0, 28'd0, 64'd0, -1);
         end
      end

      // Reset during write beat 3, then full re-init and one more read
      run_txn(1'b1, 28'($urandom), {$urandom, $urandom}, 64'd0,
              1'b0, 1'b0, 28'd0, 64'd0, 3);
      repeat (2) @(posedge CK);
      do_init(1'b0);
      run_txn(1'b0, 28'($urandom), 64'd0, {$urandom, $urandom},
              1'b0, 1'b0, 28'd0, 64'd0, -1);
      run_txn(1'b1, 28'($urandom), {$urandom, $urandom}, 64'd0,
              1'b0, 1'b0, 28'd0, 64'd0, -1);

      repeat (4) @(posedge CK);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
